// File: rtl/ann_pkg.sv
// ann_pkg: shared definitions for the ANN front-end loader.
// Holds the load-bus target codes, the header tag, default geometry,
// the sequencer state type and small header helper functions.
package ann_pkg;

  localparam int ROWS_DEFAULT   = 28;
  localparam int ADR_W_DEFAULT  = 5;
  localparam int DATA_W_DEFAULT = 21;

  localparam logic [1:0] MAT_INPUT = 2'b00;
  localparam logic [1:0] MAT_HID_W = 2'b01;
  localparam logic [1:0] MAT_OUT_W = 2'b10;
  localparam logic [1:0] MAT_IDLE  = 2'b11;

  localparam logic [2:0] HDR_TAG = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_t;

  // A header names a real matrix only when the tag matches and the
  // selector is not the idle code.
  function automatic logic hdr_ok(input logic [2:0] tag, input logic [1:0] sel);
    return (tag == HDR_TAG) && (sel != MAT_IDLE);
  endfunction

  function automatic logic [2:0] mat_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      MAT_INPUT: oh = 3'b001;
      MAT_HID_W: oh = 3'b010;
      MAT_OUT_W: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ann_load_sequencer_if.sv
// ann_load_sequencer_if: stream input plus matrix load bus.
//   s_valid/s_ready/s_data : valid/ready word stream (header, then rows)
//   mat_sel/adr/w2         : one-cycle row writes; mat_sel==11 means idle
// master: stream producer / load-bus observer. slave: the sequencer.
interface ann_load_sequencer_if
  import ann_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADR_W  = ADR_W_DEFAULT
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [1:0]        mat_sel;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] w2;

  modport master (output s_valid, s_data, input s_ready, mat_sel, adr, w2);
  modport slave  (input s_valid, s_data, output s_ready, mat_sel, adr, w2);
endinterface

// File: rtl/ann_load_sequencer.sv
// ann_load_sequencer: replays framed stream data as row writes on the
// matrix load bus and tracks which matrices are loaded.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   bus       : slave side of ann_load_sequencer_if (stream + load bus)
//   flush     : synchronous abort of the frame in progress
//   clear     : synchronous clear of the loaded mask
//   loaded    : bit0 input, bit1 hidden weights, bit2 output weights
//   layer_go  : one-cycle pulse once all three matrices are present
//   hdr_err   : sticky bad-header flag, cleared only by rst
module ann_load_sequencer
  import ann_pkg::*;
#(
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int ADR_W  = ADR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  ann_load_sequencer_if.slave       bus,
  input  logic                      flush,
  input  logic                      clear,
  output logic [2:0]                loaded,
  output logic                      layer_go,
  output logic                      hdr_err
);

  state_t           state, state_nxt;
  logic [1:0]       target, target_nxt;
  logic [ADR_W-1:0] row_cnt, row_cnt_nxt;
  logic             xfer;
  logic             row_write;
  logic             hdr_bad;
  logic             last_row;
  logic [2:0]       loaded_set;

  // Nothing is accepted while flushing or during the one-cycle DONE state.
  assign bus.s_ready = (state != DONE) && !flush;
  assign xfer        = bus.s_valid && bus.s_ready;
  assign last_row    = (row_cnt == ADR_W'(ROWS - 1));
  assign loaded_set  = loaded | mat_onehot(target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      target  <= MAT_IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      target  <= target_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    row_cnt_nxt = row_cnt;
    row_write   = 1'b0;
    hdr_bad     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok(bus.s_data[DATA_W-1 -: 3], bus.s_data[1:0])) begin
            target_nxt  = bus.s_data[1:0];
            row_cnt_nxt = '0;
            state_nxt   = DATA;
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      DATA: begin
        // xfer is already blocked by flush, so the two branches never overlap.
        if (flush) begin
          state_nxt   = IDLE;
          row_cnt_nxt = '0;
        end else if (xfer) begin
          row_write = 1'b1;
          if (last_row) begin
            state_nxt   = DONE;
            row_cnt_nxt = '0;
          end else begin
            row_cnt_nxt = row_cnt + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The consumer writes whenever mat_sel != 11, so mat_sel must fall back
  // to idle on every cycle that is not a registered row write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mat_sel <= MAT_IDLE;
      bus.adr     <= '0;
      bus.w2      <= '0;
    end else begin
      bus.mat_sel <= row_write ? target : MAT_IDLE;
      if (row_write) begin
        bus.adr <= row_cnt;
        bus.w2  <= bus.s_data;
      end
    end
  end

  // clear wins over the DONE-cycle set and also suppresses layer_go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded   <= 3'b000;
      layer_go <= 1'b0;
      hdr_err  <= 1'b0;
    end else begin
      layer_go <= 1'b0;
      if (hdr_bad) begin
        hdr_err <= 1'b1;
      end
      if (clear) begin
        loaded <= 3'b000;
      end else if (state == DONE) begin
        loaded   <= loaded_set;
        layer_go <= (loaded_set == 3'b111);
      end
    end
  end

endmodule

// File: tb/tb_ann_load_sequencer.sv
// tb_ann_load_sequencer: self-checking bench for ann_load_sequencer.
// Expected row writes go into a scoreboard queue when stimulus is driven;
// a negedge monitor pops and compares them when the load bus shows a write.
module tb_ann_load_sequencer;
  import ann_pkg::*;

  localparam int ROWS   = 28;
  localparam int ADR_W  = 5;
  localparam int DATA_W = 21;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       clear;
  logic [2:0] loaded;
  logic       layer_go;
  logic       hdr_err;

  ann_load_sequencer_if #(.DATA_W(DATA_W), .ADR_W(ADR_W)) bus ();

  ann_load_sequencer #(.ROWS(ROWS), .ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .clear    (clear),
    .loaded   (loaded),
    .layer_go (layer_go),
    .hdr_err  (hdr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        mat_sel;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] w2;
    int                due;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] hdr;
    bit                ok;
    logic              err;
  } hdr_vec_t;

  wr_t      exp_q[$];
  wr_t      mon_e;
  hdr_vec_t hv[5];
  int       n_cmp    = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       go_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Load-bus monitor: every non-idle cycle must match the queue head,
  // and any queued write whose cycle has passed was missed.
  always @(negedge clk) begin
    if (layer_go === 1'b1) go_count++;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checkOutput("missing_write_cycle", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (bus.mat_sel !== MAT_IDLE) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {bus.mat_sel, bus.adr, bus.w2}, {MAT_IDLE, 5'd0, 21'd0});
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("write_data", {bus.mat_sel, bus.adr, bus.w2}, {mon_e.mat_sel, mon_e.adr, mon_e.w2});
        checkOutput("write_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic f, input logic c);
    @(posedge clk);
    #1;
    bus.s_valid = v;
    bus.s_data  = d;
    flush       = f;
    clear       = c;
  endtask

  task automatic pushRow(input logic [1:0] tgt, input int r, input int val);
    exp_q.push_back('{mat_sel: tgt, adr: ADR_W'(r), w2: DATA_W'(val), due: cyc + 1});
  endtask

  function automatic logic [DATA_W-1:0] hdrWord(input logic [1:0] tgt);
    return {HDR_TAG, 16'd0, tgt};
  endfunction

  task automatic sendFrame(input logic [1:0] tgt, input int base, input int rows, input bit throttle);
    applyStimulus(1'b1, hdrWord(tgt), 1'b0, 1'b0);
    @(negedge clk) checkOutput("hdr_ready", bus.s_ready, 1);
    for (int r = 0; r < rows; r++) begin
      if (throttle && (r % 2 == 1)) applyStimulus(1'b0, '1, 1'b0, 1'b0);
      applyStimulus(1'b1, DATA_W'(base + r), 1'b0, 1'b0);
      pushRow(tgt, r, base + r);
      if (throttle && (r % 2 == 1)) begin
        @(negedge clk) checkOutput("throttle_idle_bus", bus.mat_sel, MAT_IDLE);
      end
    end
  endtask

  task automatic finishFrame(input logic [2:0] exp_loaded, input logic exp_go, input logic clr);
    applyStimulus(1'b0, '0, 1'b0, clr);
    @(negedge clk) checkOutput("done_ready", bus.s_ready, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("loaded", loaded, exp_loaded);
    checkOutput("layer_go", layer_go, exp_go);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk) checkOutput("layer_go_after", layer_go, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    flush       = 1'b0;
    clear       = 1'b0;

    hv[0] = '{hdr: 21'h140002, ok: 1'b1, err: 1'b0};
    hv[1] = '{hdr: 21'h17FFFD, ok: 1'b1, err: 1'b0};
    hv[2] = '{hdr: 21'h000001, ok: 1'b0, err: 1'b1};
    hv[3] = '{hdr: 21'h140003, ok: 1'b0, err: 1'b1};
    hv[4] = '{hdr: 21'h140000, ok: 1'b1, err: 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("rst_mat_sel", bus.mat_sel, MAT_IDLE);
    checkOutput("rst_adr", bus.adr, 0);
    checkOutput("rst_w2", bus.w2, 0);
    checkOutput("rst_loaded", loaded, 0);
    checkOutput("rst_layer_go", layer_go, 0);
    checkOutput("rst_hdr_err", hdr_err, 0);
    checkOutput("rst_ready", bus.s_ready, 1);
    rst = 1'b0;

    $display("[TB] back-to-back hidden-weight frame");
    sendFrame(MAT_HID_W, 100, ROWS, 1'b0);
    finishFrame(3'b010, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    sendFrame(MAT_INPUT, 0, 10, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_mat_sel", bus.mat_sel, MAT_IDLE);
    checkOutput("midrst_adr", bus.adr, 0);
    checkOutput("midrst_loaded", loaded, 0);
    checkOutput("midrst_ready", bus.s_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] three frames, throttled middle frame, then reload");
    sendFrame(MAT_INPUT, 300, ROWS, 1'b0);
    finishFrame(3'b001, 1'b0, 1'b0);
    sendFrame(MAT_HID_W, 400, ROWS, 1'b1);
    finishFrame(3'b011, 1'b0, 1'b0);
    sendFrame(MAT_OUT_W, 600, ROWS, 1'b0);
    finishFrame(3'b111, 1'b1, 1'b0);
    sendFrame(MAT_HID_W, 700, ROWS, 1'b0);
    finishFrame(3'b111, 1'b1, 1'b0);

    $display("[TB] clear, then clear during the third DONE");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk) checkOutput("clear_loaded", loaded, 0);
    sendFrame(MAT_INPUT, 800, ROWS, 1'b0);
    finishFrame(3'b001, 1'b0, 1'b0);
    sendFrame(MAT_HID_W, 900, ROWS, 1'b0);
    finishFrame(3'b011, 1'b0, 1'b0);
    sendFrame(MAT_OUT_W, 1000, ROWS, 1'b0);
    finishFrame(3'b000, 1'b0, 1'b1);

    $display("[TB] header vector table");
    foreach (hv[i]) begin
      applyStimulus(1'b1, hv[i].hdr, 1'b0, 1'b0);
      applyStimulus(1'b1, 21'h000055, 1'b0, 1'b0);
      if (hv[i].ok) pushRow(hv[i].hdr[1:0], 0, 'h55);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge clk) checkOutput("flush_ready", bus.s_ready, 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("hdr_err", hdr_err, hv[i].err);
      checkOutput("hdr_loaded", loaded, 0);
    end

    $display("[TB] flush after row 5");
    sendFrame(MAT_OUT_W, 500, 6, 1'b0);
    applyStimulus(1'b1, 21'h000099, 1'b1, 1'b0);
    @(negedge clk) checkOutput("flush_word_ready", bus.s_ready, 0);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk) checkOutput("flush_loaded", loaded, 0);
    sendFrame(MAT_INPUT, 200, ROWS, 1'b0);
    finishFrame(3'b001, 1'b0, 1'b0);

    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 0);
    checkOutput("go_count", go_count, 2);
    checkOutput("hdr_err_sticky", hdr_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ann_load_sequencer.md
Name: ann_load_sequencer

Overview:
- Front-end loader for the ANN datapath. Accepts a valid/ready word stream of framed matrix data: one header word, then ROWS row words.
- Replays each frame as one-cycle row writes on the mat_sel/adr/w2 load bus of the matrix-multiply/decision stage.
- Tracks which of the three matrices (input, hidden weights, output weights) are loaded. Pulses layer_go when a frame completes and all three are present.

Parameters:
- ROWS, 28, row words per frame; adr counts 0..ROWS-1.
- ADR_W, 5, width of adr; must satisfy 2**ADR_W >= ROWS.
- DATA_W, 21, width of stream and w2 bus.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  stream word valid.
- s_ready  out  1  block can accept a word.
- s_data  in  DATA_W  stream word (header or row).
- flush  in  1  synchronous abort of the current frame.
- clear  in  1  synchronous clear of the loaded mask.
- mat_sel  out  2  load target: 00 input, 01 hidden weights, 10 output weights, 11 idle.
- adr  out  ADR_W  row address.
- w2  out  DATA_W  row data.
- loaded  out  3  bit0 input, bit1 hidden weights, bit2 output weights.
- layer_go  out  1  one-cycle pulse: start evaluation.
- hdr_err  out  1  sticky bad-header flag.

Behaviour:
- Reset values (asynchronous, while rst=1): state=IDLE, mat_sel=2'b11, adr=0, w2=0, loaded=0, layer_go=0, hdr_err=0, row counter=0.
- Load bus rule: the consumer has no write enable and writes whenever mat_sel!=11. mat_sel therefore equals 11 on every cycle except a write cycle.
- Transfer: occurs when s_valid && s_ready.
- s_ready = 1 in IDLE and DATA; 0 in DONE.
- Header format: s_data[20:18] must be 3'b101 and s_data[1:0] must not be 11. s_data[1:0] selects the target. Other bits are ignored.
- IDLE:
  - Valid header transfer: latch target, clear row counter, go to DATA.
  - Invalid header transfer: set hdr_err, drop the word, stay in IDLE.
- DATA:
  - Each transfer at cycle n drives mat_sel=target, adr=row counter, w2=s_data at cycle n+1, for exactly one cycle. Latency is 1, with no bubbles required between words.
  - Counter increments per transfer.
  - The transfer with counter==ROWS-1 moves the FSM to DONE.
  - No transfer (s_valid=0): bus is idle (11); state and counter hold.
- DONE (exactly one cycle):
  - loaded |= onehot(target).
  - If the new loaded value == 3'b111, layer_go=1 in the following cycle, coincident with loaded already updated.
  - Then return to IDLE.
  - Reloading any matrix while the mask is full re-fires layer_go.
- flush=1:
  - In DATA: return to IDLE next cycle; counter=0.
  - A write registered in the same cycle is still presented. Rows already written stay in the consumer; loaded is not updated.
  - Words offered in the flush cycle are not accepted; s_ready=0 while flush=1.
- clear=1: loaded=0 next cycle; layer_go suppressed that cycle. Clear in the DONE cycle takes precedence over the set.
- hdr_err: clears only on rst.
- Counter width: ADR_W bits; never exceeds ROWS-1, so no wrap.
- rst mid-frame: everything returns to reset values immediately; the partial frame is discarded.

Decomposition:
- Shared package ann_pkg:
  - MAT_INPUT=2'b00, MAT_HID_W=2'b01, MAT_OUT_W=2'b10, MAT_IDLE=2'b11.
  - HDR_TAG=3'b101.
  - ROWS/ADR_W/DATA_W defaults.
  - FSM state enum {IDLE, DATA, DONE}.
- Single module. No sub-module needed; the header check is a small function in ann_pkg.

Test Plan:
- Reset mid-frame: rst after 10 rows -> mat_sel=11, adr=0, loaded=000, s_ready=1 in IDLE. A new header is then accepted normally.
- Header 0x140001 (tag 101, target 01), then 28 back-to-back rows 0..27 with value 100+row:
  - 28 consecutive write cycles, mat_sel=01, adr=0..27, w2=100..127, each one cycle after acceptance.
  - Then loaded=010 and no layer_go.
- Frames for targets 00, 01, 10 in sequence:
  - layer_go pulses exactly once, two cycles after the last row of the third frame is accepted; loaded=111.
  - A further 01 frame pulses layer_go again.
- Bad headers 0x000001 (bad tag) and 0x140003 (target 11):
  - hdr_err=1, no writes (mat_sel stays 11), state stays IDLE.
  - The next valid header is accepted.
- Throttled stream: s_valid toggled 1,0,1,0 -> mat_sel=11 on idle cycles; adr increments only per transfer.
- Corner cases:
  - flush after row 5: IDLE, loaded unchanged, no more writes.
  - clear asserted in the DONE cycle of the third frame: loaded=000, no layer_go.
